// File: rtl/tarsier_pkg.sv
// tarsier_pkg: constants and helpers shared by the orientation pipeline.
//   ANGLE_BITS / NUM_SECTORS : sector encoding shared with the sector selector
//   hist_state_t             : orient_hist FSM states
//   sat_add                  : unsigned add clamped to a run-time width
package tarsier_pkg;

    localparam int unsigned ANGLE_BITS  = 6;
    localparam int unsigned NUM_SECTORS = 64;

    // Widest accumulator sat_add can handle; callers zero-extend into this.
    localparam int unsigned SAT_BITS = 32;

    typedef enum logic {
        ACCUM,
        DUMP
    } hist_state_t;

    // Returns min(a + b, 2^width - 1). width must be 1..SAT_BITS.
    function automatic logic [SAT_BITS-1:0] sat_add(
        input logic [SAT_BITS-1:0] a,
        input logic [SAT_BITS-1:0] b,
        input int unsigned         width
    );
        logic [SAT_BITS:0] one;
        logic [SAT_BITS:0] sum;
        logic [SAT_BITS:0] lim;
        one = {{SAT_BITS{1'b0}}, 1'b1};
        sum = {1'b0, a} + {1'b0, b};
        lim = (one << width) - one;
        if (sum > lim) begin
            return lim[SAT_BITS-1:0];
        end
        return sum[SAT_BITS-1:0];
    endfunction

endpackage

// File: rtl/orient_hist.sv
// orient_hist: per-cell 64-bin weighted orientation histogram.
// Accumulates samples in ACCUM; on the cell's last sample switches to DUMP and
// streams bins 0..63 over a valid/ready port, clearing each bin as it is read.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready            sample handshake (in_ready high only in ACCUM)
//   in_sector, in_nan            sample sector and "no defined angle" flag
//   in_weight, in_last           magnitude weight, final sample of cell
//   out_valid/out_ready          bin beat handshake
//   out_bin, out_count           bin index and its accumulated weight
//   out_nan_count, out_last      NaN sample count, beat is bin 63
//   dropped                      sticky: sample offered while in_ready=0
module orient_hist
    import tarsier_pkg::*;
#(
    parameter int unsigned WEIGHT_BITS = 16,
    parameter int unsigned COUNT_BITS  = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ANGLE_BITS-1:0]  in_sector,
    input  logic                   in_nan,
    input  logic [WEIGHT_BITS-1:0] in_weight,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ANGLE_BITS-1:0]  out_bin,
    output logic [COUNT_BITS-1:0]  out_count,
    output logic [COUNT_BITS-1:0]  out_nan_count,
    output logic                   out_last,
    output logic                   dropped
);

    localparam logic [ANGLE_BITS-1:0] LAST_IDX = ANGLE_BITS'(NUM_SECTORS - 1);

    hist_state_t             r_state;
    hist_state_t             w_state_next;
    logic [ANGLE_BITS-1:0]   r_idx;
    logic [COUNT_BITS-1:0]   r_bins [NUM_SECTORS];
    logic [COUNT_BITS-1:0]   r_nan_count;
    logic                    r_dropped;

    logic                    w_accept;
    logic                    w_beat_done;
    logic [COUNT_BITS-1:0]   w_bin_sum;
    logic [COUNT_BITS-1:0]   w_nan_sum;

    assign w_accept    = in_valid && (r_state == ACCUM);
    assign w_beat_done = (r_state == DUMP) && out_ready;

    assign w_bin_sum = COUNT_BITS'(sat_add(SAT_BITS'(r_bins[in_sector]),
                                           SAT_BITS'(in_weight), COUNT_BITS));
    assign w_nan_sum = COUNT_BITS'(sat_add(SAT_BITS'(r_nan_count),
                                           SAT_BITS'(1), COUNT_BITS));

    assign dropped = r_dropped;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= '0;
            r_nan_count <= '0;
            r_dropped   <= 1'b0;
            for (int i = 0; i < NUM_SECTORS; i++) begin
                r_bins[i] <= '0;
            end
        end else begin
            // ACCUM write and DUMP clear are mutually exclusive by state.
            if (w_accept && !in_nan) begin
                r_bins[in_sector] <= w_bin_sum;
            end
            if (w_beat_done) begin
                r_bins[r_idx] <= '0;
                // 6-bit index wraps 63 -> 0, leaving it ready for the next dump.
                r_idx         <= r_idx + 1'b1;
            end

            if (w_accept && in_nan) begin
                r_nan_count <= w_nan_sum;
            end else if (w_beat_done && (r_idx == LAST_IDX)) begin
                r_nan_count <= '0;
            end

            if (in_valid && (r_state == DUMP)) begin
                r_dropped <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        out_bin       = '0;
        out_count     = '0;
        out_nan_count = '0;
        out_last      = 1'b0;
        case (r_state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    w_state_next = DUMP;
                end
            end
            DUMP: begin
                out_valid     = 1'b1;
                out_bin       = r_idx;
                out_count     = r_bins[r_idx];
                out_nan_count = r_nan_count;
                out_last      = (r_idx == LAST_IDX);
                if (out_ready && (r_idx == LAST_IDX)) begin
                    w_state_next = ACCUM;
                end
            end
            default: w_state_next = ACCUM;
        endcase
    end

endmodule

// File: tb/tb_orient_hist.sv
// tb_orient_hist: self-checking bench for orient_hist. A bin-array model fed by
// the same samples predicts every dump beat; a second 16-bit instance covers
// accumulator saturation.
module tb_orient_hist;

    localparam int unsigned MAX24 = (1 << 24) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_sector = '0;
    logic        in_nan = 1'b0;
    logic [15:0] in_weight = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [5:0]  out_bin;
    logic [23:0] out_count;
    logic [23:0] out_nan_count;
    logic        out_last;
    logic        dropped;

    logic        s_in_valid = 1'b0;
    logic        s_in_ready;
    logic [5:0]  s_in_sector = '0;
    logic [15:0] s_in_weight = '0;
    logic        s_in_last = 1'b0;
    logic        s_out_valid;
    logic        s_out_ready = 1'b0;
    logic [5:0]  s_out_bin;
    logic [15:0] s_out_count;
    logic [15:0] s_out_nan_count;
    logic        s_out_last;
    logic        s_dropped;

    int n_vec = 0;
    int n_err = 0;

    longint m_bins [64];
    longint m_nan;
    bit     m_dumping;

    always #5 clk = ~clk;

    orient_hist #(.WEIGHT_BITS(16), .COUNT_BITS(24)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sector(in_sector),
        .in_nan(in_nan), .in_weight(in_weight), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin),
        .out_count(out_count), .out_nan_count(out_nan_count),
        .out_last(out_last), .dropped(dropped)
    );

    orient_hist #(.WEIGHT_BITS(16), .COUNT_BITS(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_sector(s_in_sector),
        .in_nan(1'b0), .in_weight(s_in_weight), .in_last(s_in_last),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_bin(s_out_bin),
        .out_count(s_out_count), .out_nan_count(s_out_nan_count),
        .out_last(s_out_last), .dropped(s_dropped)
    );

    function automatic void model_clear();
        for (int i = 0; i < 64; i++) m_bins[i] = 0;
        m_nan     = 0;
        m_dumping = 1'b0;
    endfunction

    // Offer one sample for one cycle; the model takes it only outside a dump.
    task automatic send(input int sec, input bit nan, input int w, input bit last);
        @(negedge clk);
        in_valid  = 1'b1;
        in_sector = 6'(sec);
        in_nan    = nan;
        in_weight = 16'(w);
        in_last   = last;
        @(posedge clk);
        if (!m_dumping) begin
            if (nan) begin
                m_nan = (m_nan + 1 > MAX24) ? MAX24 : m_nan + 1;
            end else begin
                m_bins[sec] = (m_bins[sec] + w > MAX24) ? MAX24 : m_bins[sec] + w;
            end
            if (last) m_dumping = 1'b1;
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_nan   = 1'b0;
    endtask

    // Drain one dump, checking every beat against the model.
    task automatic collect_dump(input bit rand_ready, input bit stall17, input string tag);
        int          exp_idx    = 0;
        int          stall_left = stall17 ? 5 : 0;
        bit          done       = 1'b0;
        bit          aborted    = 1'b0;
        bit          prev_stall = 1'b0;
        bit          r;
        logic [5:0]  pb = '0;
        logic [23:0] pc = '0;
        for (int cyc = 0; cyc < 2000 && !done && !aborted; cyc++) begin
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL %s handshake beat %0d: out_valid=%b in_ready=%b, required 1/0",
                         tag, exp_idx, out_valid, in_ready);
                aborted = 1'b1;
            end else begin
                n_vec++;
                if (out_bin !== 6'(exp_idx) || out_count !== 24'(m_bins[exp_idx]) ||
                    out_last !== (exp_idx == 63) || out_nan_count !== 24'(m_nan)) begin
                    n_err++;
                    $display("FAIL %s beat %0d: bin=%0d count=%0d last=%b nan=%0d, required bin=%0d count=%0d last=%b nan=%0d",
                             tag, exp_idx, out_bin, out_count, out_last, out_nan_count,
                             exp_idx, m_bins[exp_idx], (exp_idx == 63), m_nan);
                end
                if (prev_stall) begin
                    n_vec++;
                    if (out_bin !== pb || out_count !== pc) begin
                        n_err++;
                        $display("FAIL %s stall stability: bin=%0d count=%0d, required bin=%0d count=%0d",
                                 tag, out_bin, out_count, pb, pc);
                    end
                end
                if (exp_idx == 17 && stall_left > 0) begin
                    r = 1'b0;
                    stall_left--;
                end else if (rand_ready) begin
                    r = ($urandom_range(0, 3) != 0);
                end else begin
                    r = 1'b1;
                end
                out_ready  = r;
                prev_stall = !r;
                pb         = out_bin;
                pc         = out_count;
                if (r) begin
                    if (exp_idx == 63) done = 1'b1;
                    exp_idx++;
                end
            end
        end
        if (!done && !aborted) begin
            n_err++;
            $display("FAIL %s timeout: %0d beats seen, required 64", tag, exp_idx);
        end
        @(negedge clk);
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s dump end: out_valid=%b in_ready=%b, required 0/1",
                     tag, out_valid, in_ready);
        end
        model_clear();
    endtask

    task automatic test_reset();
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_bin !== 6'd0 ||
            out_count !== 24'd0 || out_nan_count !== 24'd0 || out_last !== 1'b0 ||
            dropped !== 1'b0) begin
            n_err++;
            $display("FAIL reset: in_ready=%b out_valid=%b bin=%0d count=%0d nan=%0d last=%b dropped=%b, required 1 0 0 0 0 0 0",
                     in_ready, out_valid, out_bin, out_count, out_nan_count, out_last, dropped);
        end
    endtask

    task automatic test_basic_cell();
        send(5, 1'b0, 100, 1'b0);
        send(5, 1'b0, 20, 1'b0);
        send(63, 1'b0, 7, 1'b1);
        collect_dump(1'b0, 1'b0, "basic");
        send(0, 1'b0, 3, 1'b1);
        collect_dump(1'b0, 1'b0, "second_cell");
    endtask

    task automatic test_nan();
        send(0, 1'b1, 999, 1'b0);
        send(0, 1'b0, 999, 1'b0);
        send(0, 1'b1, 999, 1'b0);
        send(0, 1'b0, 999, 1'b1);
        collect_dump(1'b0, 1'b0, "nan");
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            s_in_valid  = 1'b1;
            s_in_sector = 6'd10;
            s_in_weight = 16'hFFFF;
            s_in_last   = (k == 2);
            @(posedge clk);
            #1;
            s_in_valid = 1'b0;
            s_in_last  = 1'b0;
        end
        for (int b = 0; b < 64; b++) begin
            @(negedge clk);
            n_vec++;
            if (s_out_valid !== 1'b1 || s_out_bin !== 6'(b) ||
                s_out_count !== ((b == 10) ? 16'hFFFF : 16'h0000)) begin
                n_err++;
                $display("FAIL saturate beat %0d: valid=%b bin=%0d count=%h, required 1 %0d %h",
                         b, s_out_valid, s_out_bin, s_out_count, b,
                         (b == 10) ? 16'hFFFF : 16'h0000);
            end
            s_out_ready = 1'b1;
        end
        @(negedge clk);
        s_out_ready = 1'b0;
        n_vec++;
        if (s_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL saturate end: out_valid=%b, required 0", s_out_valid);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 12; i++) begin
            send($urandom_range(0, 63), 1'b0, $urandom_range(0, 65535), i == 11);
        end
        collect_dump(1'b1, 1'b1, "stall");
    endtask

    task automatic test_drop();
        send(2, 1'b0, 11, 1'b0);
        send(40, 1'b0, 300, 1'b1);
        send(2, 1'b0, 55, 1'b0);
        collect_dump(1'b1, 1'b0, "drop_cell");
        n_vec++;
        if (dropped !== 1'b1) begin
            n_err++;
            $display("FAIL drop flag: dropped=%b, required 1", dropped);
        end
        send(2, 1'b0, 9, 1'b0);
        send(3, 1'b0, 1, 1'b1);
        collect_dump(1'b1, 1'b0, "after_drop");
        n_vec++;
        if (dropped !== 1'b1) begin
            n_err++;
            $display("FAIL drop sticky: dropped=%b, required 1", dropped);
        end
    endtask

    task automatic test_random_cells();
        for (int c = 0; c < 3; c++) begin
            int n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) begin
                send($urandom_range(0, 63), $urandom_range(0, 7) == 0,
                     $urandom_range(0, 65535), i == n - 1);
            end
            collect_dump(1'b1, 1'b0, "random");
        end
    endtask

    task automatic test_reset_mid_dump();
        bit hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            send($urandom_range(0, 63), 1'b0, $urandom_range(1, 65535), i == 19);
        end
        for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_bin === 6'd30) begin
                rst       = 1'b1;
                out_ready = 1'b1;
                hit       = 1'b1;
            end else begin
                out_ready = 1'b1;
            end
        end
        n_vec++;
        if (!hit) begin
            n_err++;
            $display("FAIL rst_mid_dump: bin 30 beat not reached, required reached");
        end
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || dropped !== 1'b0 || out_bin !== 6'd0) begin
            n_err++;
            $display("FAIL rst_mid_dump state: out_valid=%b in_ready=%b dropped=%b bin=%0d, required 0 1 0 0",
                     out_valid, in_ready, dropped, out_bin);
        end
        rst       = 1'b0;
        out_ready = 1'b0;
        model_clear();
        send(1, 1'b0, 4, 1'b1);
        collect_dump(1'b0, 1'b0, "post_rst");
    endtask

    initial begin
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_basic_cell();
        test_nan();
        test_saturation();
        test_stall();
        test_drop();
        test_random_cells();
        test_reset_mid_dump();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
